// File: rtl/mrd_sink_wrgen.sv
// Sink-side write generator for the mixed-radix DFT memory.
// Spreads a streaming frame round-robin over NBANK single-port banks
// (sample k -> bank k mod NBANK, address k div NBANK) and raises the
// frame-progress strobes and the Sink-state timeout for the top FSM.
//
// Handshake: the input is a plain valid stream with no backpressure.
// A sample is accepted on every rising clk edge where in_valid is high;
// in_sop/in_eop are only meaningful together with in_valid. A low in_valid
// ends the frame and the next accepted sample is k = 0 again.
module mrd_sink_wrgen #(
  parameter int NBANK     = 7,
  parameter int wADDR     = 8,
  parameter int wCNT      = 12,
  parameter int wDATA     = 36,
  parameter int TIMEOUT   = 2047,
  parameter int TWDL_LEAD = 6
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             fsm_sink,
  input  logic [wCNT-1:0]  frame_len,
  input  logic             in_valid,
  input  logic             in_sop,
  input  logic             in_eop,
  input  logic [wDATA-1:0] in_data,
  output logic [NBANK-1:0] wr_en,
  output logic [wADDR-1:0] wr_addr,
  output logic [wDATA-1:0] wr_data,
  output logic             frame_done,
  output logic             len_err,
  output logic             sink_3_4,
  output logic             twdl_sop_sink,
  output logic             over_time
);

  localparam int BW = (NBANK > 1) ? $clog2(NBANK) : 1;
  localparam logic [BW-1:0]   LAST_BANK = BW'(NBANK - 1);
  localparam logic [wCNT:0]   ONE_X     = (wCNT+1)'(1);
  localparam logic [wCNT:0]   LEAD_X    = (wCNT+1)'(TWDL_LEAD);
  localparam logic [wCNT-1:0] TMO       = wCNT'(TIMEOUT);

  // Pointers for the next sample of the current frame
  logic [wCNT-1:0]  k_r;
  logic [BW-1:0]    bank_r;
  logic [wADDR-1:0] addr_r;
  logic             err_sent_r;

  // View of the sample presented this cycle (in_sop restarts at zero)
  logic [wCNT-1:0]  k_cur;
  logic [BW-1:0]    bank_cur;
  logic [wADDR-1:0] addr_cur;
  logic             err_sent_cur;
  logic [wCNT:0]    k_ext;
  logic [wCNT:0]    n_ext;
  logic [wCNT:0]    pt_sum;
  logic [wCNT:0]    q_pt;
  logic [wCNT:0]    t_pt;
  logic             drop;
  logic             do_wr;
  logic             is_last;
  logic             eop_err;
  logic             first_drop;
  logic             hit_q;
  logic             hit_t;

  // Pointer stage registers
  logic             s1_wr;
  logic [BW-1:0]    s1_bank;
  logic [wADDR-1:0] s1_addr;
  logic [wDATA-1:0] s1_data;
  logic             s1_done;
  logic             s1_err;
  logic [NBANK-1:0] s1_onehot;

  // Sink-state cycle counter
  logic [wCNT-1:0]  tmo_cnt;

  // Classify the incoming sample against the frame length and strobe points
  always_comb begin
    k_cur        = in_sop ? '0 : k_r;
    bank_cur     = in_sop ? '0 : bank_r;
    addr_cur     = in_sop ? '0 : addr_r;
    err_sent_cur = in_sop ? 1'b0 : err_sent_r;
    k_ext        = {1'b0, k_cur};
    n_ext        = {1'b0, frame_len};
    // 3N/4 built from the two shifted copies of N, one bit wider than N
    pt_sum       = {3'b000, frame_len[wCNT-1:2]} + {2'b00, frame_len[wCNT-1:1]};
    q_pt         = pt_sum - ONE_X;
    t_pt         = pt_sum - LEAD_X;
    drop         = (k_ext >= n_ext);
    do_wr        = in_valid && !drop;
    // n_ext - 1 wraps to all ones for N = 0, which no k can match
    is_last      = (k_ext == (n_ext - ONE_X));
    eop_err      = do_wr && in_eop && !is_last;
    first_drop   = in_valid && drop && !err_sent_cur;
    hit_q        = in_valid && (k_ext == q_pt) && (k_cur != '0);
    hit_t        = in_valid && !t_pt[wCNT] && (k_ext == t_pt);
  end

  // Advance sample index, bank pointer and address pointer
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      k_r        <= '0;
      bank_r     <= '0;
      addr_r     <= '0;
      err_sent_r <= 1'b0;
    end else if (!in_valid || in_eop) begin
      k_r        <= '0;
      bank_r     <= '0;
      addr_r     <= '0;
      err_sent_r <= 1'b0;
    end else if (drop) begin
      // Excess samples park the index at N so it can never wrap back in range
      k_r        <= k_cur;
      bank_r     <= bank_cur;
      addr_r     <= addr_cur;
      err_sent_r <= 1'b1;
    end else begin
      k_r        <= k_cur + 1'b1;
      err_sent_r <= err_sent_cur;
      if (bank_cur == LAST_BANK) begin
        bank_r <= '0;
        addr_r <= addr_cur + 1'b1;
      end else begin
        bank_r <= bank_cur + 1'b1;
        addr_r <= addr_cur;
      end
    end
  end

  // Pointer stage: capture the write and the one-cycle strobes
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1_wr         <= 1'b0;
      s1_bank       <= '0;
      s1_addr       <= '0;
      s1_data       <= '0;
      s1_done       <= 1'b0;
      s1_err        <= 1'b0;
      sink_3_4      <= 1'b0;
      twdl_sop_sink <= 1'b0;
    end else begin
      s1_wr         <= do_wr;
      s1_bank       <= bank_cur;
      s1_addr       <= addr_cur;
      s1_data       <= in_data;
      s1_done       <= do_wr && is_last;
      s1_err        <= eop_err || first_drop;
      sink_3_4      <= hit_q;
      twdl_sop_sink <= hit_t;
    end
  end

  // Bank 0 sits on the MSB of the write-enable vector
  always_comb begin
    s1_onehot = '0;
    for (int i = 0; i < NBANK; i++) begin
      s1_onehot[NBANK-1-i] = (s1_bank == BW'(i));
    end
  end

  // Output register: write port and frame status pulses
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_en      <= '0;
      wr_addr    <= '0;
      wr_data    <= '0;
      frame_done <= 1'b0;
      len_err    <= 1'b0;
    end else begin
      wr_en      <= s1_wr ? s1_onehot : '0;
      frame_done <= s1_done;
      len_err    <= s1_err;
      if (s1_wr) begin
        wr_addr <= s1_addr;
        wr_data <= s1_data;
      end
    end
  end

  // Saturating Sink-state timeout; level output held until fsm_sink drops
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      tmo_cnt   <= '0;
      over_time <= 1'b0;
    end else if (!fsm_sink) begin
      tmo_cnt   <= '0;
      over_time <= 1'b0;
    end else begin
      if (tmo_cnt != TMO) begin
        tmo_cnt <= tmo_cnt + 1'b1;
      end
      over_time <= (tmo_cnt == TMO);
    end
  end

endmodule

// File: tb/tb_mrd_sink_wrgen.sv
// Bench for mrd_sink_wrgen: table of frame scenarios with hand-derived
// totals, per-cycle comparison against a sample-level reference model,
// randomized frames, plus hand-written reset and timeout sequences.
module tb_mrd_sink_wrgen;

  localparam int WA = 8;
  localparam int WC = 12;
  localparam int WD = 36;
  localparam int TMO = 2047;
  localparam int LEAD = 6;
  localparam int MAXC = 256;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst_n;
  logic          fsm_sink;
  logic [WC-1:0] frame_len;
  logic          in_valid, in_sop, in_eop;
  logic [WD-1:0] in_data;

  logic [6:0]    wr_en7;
  logic [WA-1:0] wr_addr7;
  logic [WD-1:0] wr_data7;
  logic          done7, err7, s34_7, tw7, ovt7;

  logic [4:0]    wr_en5;
  logic [WA-1:0] wr_addr5;
  logic [WD-1:0] wr_data5;
  logic          done5, err5, s34_5, tw5, ovt5;

  mrd_sink_wrgen #(.NBANK(7), .wADDR(WA), .wCNT(WC), .wDATA(WD),
                   .TIMEOUT(TMO), .TWDL_LEAD(LEAD)) dut (
    .clk(clk), .rst_n(rst_n), .fsm_sink(fsm_sink), .frame_len(frame_len),
    .in_valid(in_valid), .in_sop(in_sop), .in_eop(in_eop), .in_data(in_data),
    .wr_en(wr_en7), .wr_addr(wr_addr7), .wr_data(wr_data7),
    .frame_done(done7), .len_err(err7), .sink_3_4(s34_7),
    .twdl_sop_sink(tw7), .over_time(ovt7));

  mrd_sink_wrgen #(.NBANK(5), .wADDR(WA), .wCNT(WC), .wDATA(WD),
                   .TIMEOUT(TMO), .TWDL_LEAD(LEAD)) dut5 (
    .clk(clk), .rst_n(rst_n), .fsm_sink(fsm_sink), .frame_len(frame_len),
    .in_valid(in_valid), .in_sop(in_sop), .in_eop(in_eop), .in_data(in_data),
    .wr_en(wr_en5), .wr_addr(wr_addr5), .wr_data(wr_data5),
    .frame_done(done5), .len_err(err5), .sink_3_4(s34_5),
    .twdl_sop_sink(tw5), .over_time(ovt5));

  // ---------------- scoreboard ----------------
  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // stimulus per cycle
  bit            st_v [MAXC];
  bit            st_s [MAXC];
  bit            st_e [MAXC];
  logic [WD-1:0] st_d [MAXC];

  // expected outputs per cycle (index = cycle the output is visible)
  logic [6:0]    ex_en7  [MAXC+8];
  logic [4:0]    ex_en5  [MAXC+8];
  int            ex_a7   [MAXC+8];
  int            ex_a5   [MAXC+8];
  logic [WD-1:0] ex_d    [MAXC+8];
  bit            ex_done [MAXC+8];
  bit            ex_err  [MAXC+8];
  bit            ex_s34  [MAXC+8];
  bit            ex_tw   [MAXC+8];

  task automatic clear_stim();
    logic [63:0] r;
    for (int c = 0; c < MAXC; c++) begin
      r = {$urandom, $urandom};
      st_v[c] = 0; st_s[c] = 0; st_e[c] = 0; st_d[c] = r[WD-1:0];
    end
  endtask

  // Reference model: walks the samples, k mod/div NBANK gives bank/address
  task automatic model_build(input int n, input int ncyc);
    int k;
    bit err_sent;
    int q, t;
    logic [6:0] top7;
    logic [4:0] top5;
    top7 = 7'b1000000;
    top5 = 5'b10000;
    for (int c = 0; c < MAXC + 8; c++) begin
      ex_en7[c] = '0; ex_en5[c] = '0; ex_a7[c] = 0; ex_a5[c] = 0; ex_d[c] = '0;
      ex_done[c] = 0; ex_err[c] = 0; ex_s34[c] = 0; ex_tw[c] = 0;
    end
    q = n / 4 + n / 2 - 1;
    t = n / 4 + n / 2 - LEAD;
    k = 0;
    err_sent = 0;
    for (int c = 0; c < ncyc; c++) begin
      if (!st_v[c]) begin
        k = 0; err_sent = 0;
      end else begin
        if (st_s[c]) begin k = 0; err_sent = 0; end
        if (k < n) begin
          ex_en7[c+2] = top7 >> (k % 7);
          ex_en5[c+2] = top5 >> (k % 5);
          ex_a7[c+2]  = (k / 7) % 256;
          ex_a5[c+2]  = (k / 5) % 256;
          ex_d[c+2]   = st_d[c];
          if (k == n - 1) ex_done[c+2] = 1;
          if (st_e[c] && k != n - 1) ex_err[c+2] = 1;
        end else begin
          if (!err_sent) ex_err[c+2] = 1;
          err_sent = 1;
        end
        if (k == q && k != 0) ex_s34[c+1] = 1;
        if (t >= 0 && k == t) ex_tw[c+1] = 1;
        if (k < n) k++;
        if (st_e[c]) begin k = 0; err_sent = 0; end
      end
    end
  endtask

  // Driver + per-cycle comparison; also tallies observed pulses
  task automatic run_stim(input int n, input int ncyc,
                          output int wr, output int dn, output int er,
                          output int s3, output int tw);
    wr = 0; dn = 0; er = 0; s3 = 0; tw = 0;
    frame_len = WC'(n);
    model_build(n, ncyc);
    for (int c = 0; c < ncyc + 3; c++) begin
      @(negedge clk);
      in_valid = (c < ncyc) ? st_v[c] : 1'b0;
      in_sop   = (c < ncyc) ? st_s[c] : 1'b0;
      in_eop   = (c < ncyc) ? st_e[c] : 1'b0;
      in_data  = (c < ncyc) ? st_d[c] : '0;
      @(posedge clk);
      #1;
      check($sformatf("wr_en7 n=%0d c=%0d", n, c+1), 64'(wr_en7), 64'(ex_en7[c+1]));
      check($sformatf("wr_en5 n=%0d c=%0d", n, c+1), 64'(wr_en5), 64'(ex_en5[c+1]));
      check($sformatf("frame_done n=%0d c=%0d", n, c+1), 64'(done7), 64'(ex_done[c+1]));
      check($sformatf("len_err n=%0d c=%0d", n, c+1), 64'(err7), 64'(ex_err[c+1]));
      check($sformatf("sink_3_4 n=%0d c=%0d", n, c+1), 64'(s34_7), 64'(ex_s34[c+1]));
      check($sformatf("twdl n=%0d c=%0d", n, c+1), 64'(tw7), 64'(ex_tw[c+1]));
      if (ex_en7[c+1] != '0) begin
        check($sformatf("wr_addr7 n=%0d c=%0d", n, c+1), 64'(wr_addr7), 64'(ex_a7[c+1]));
        check($sformatf("wr_addr5 n=%0d c=%0d", n, c+1), 64'(wr_addr5), 64'(ex_a5[c+1]));
        check($sformatf("wr_data n=%0d c=%0d", n, c+1), 64'(wr_data7), 64'(ex_d[c+1]));
        check($sformatf("done5 n=%0d c=%0d", n, c+1), 64'(done5), 64'(ex_done[c+1]));
      end
      if (wr_en7 != '0) wr++;
      if (done7) dn++;
      if (err7) er++;
      if (s34_7) s3++;
      if (tw7) tw++;
    end
  endtask

  typedef struct {
    int n; int len; int eop_k; int sop2;
    int w; int d; int e; int s; int t;
  } vec_t;

  vec_t tbl [8];

  initial begin
    int wr, dn, er, s3, tw;
    int n, len;
    logic [WD-1:0] dval;

    tbl[0] = '{n:28, len:28, eop_k:27, sop2:-1, w:28, d:1, e:0, s:1, t:1};
    tbl[1] = '{n:12, len:14, eop_k:-1, sop2:-1, w:12, d:1, e:1, s:1, t:1};
    tbl[2] = '{n:12, len:9,  eop_k:8,  sop2:-1, w:9,  d:0, e:1, s:1, t:1};
    tbl[3] = '{n:12, len:17, eop_k:16, sop2:5,  w:17, d:1, e:0, s:1, t:2};
    tbl[4] = '{n:4,  len:4,  eop_k:3,  sop2:-1, w:4,  d:1, e:0, s:1, t:0};
    tbl[5] = '{n:0,  len:3,  eop_k:-1, sop2:-1, w:0,  d:0, e:1, s:0, t:0};
    tbl[6] = '{n:1,  len:1,  eop_k:0,  sop2:-1, w:1,  d:1, e:0, s:0, t:0};
    tbl[7] = '{n:5,  len:1,  eop_k:0,  sop2:-1, w:1,  d:0, e:1, s:0, t:0};

    // reset state
    rst_n = 1'b0; fsm_sink = 1'b0; frame_len = '0;
    in_valid = 1'b0; in_sop = 1'b0; in_eop = 1'b0; in_data = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst wr_en", 64'(wr_en7), 64'd0);
    check("rst wr_addr", 64'(wr_addr7), 64'd0);
    check("rst wr_data", 64'(wr_data7), 64'd0);
    check("rst frame_done", 64'(done7), 64'd0);
    check("rst len_err", 64'(err7), 64'd0);
    check("rst sink_3_4", 64'(s34_7), 64'd0);
    check("rst twdl", 64'(tw7), 64'd0);
    check("rst over_time", 64'(ovt7), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // table-driven frames
    for (int i = 0; i < 8; i++) begin
      clear_stim();
      for (int c = 0; c < tbl[i].len; c++) st_v[c] = 1;
      st_s[0] = 1;
      if (tbl[i].sop2 >= 0) st_s[tbl[i].sop2] = 1;
      if (tbl[i].eop_k >= 0) st_e[tbl[i].eop_k] = 1;
      run_stim(tbl[i].n, tbl[i].len, wr, dn, er, s3, tw);
      check($sformatf("vec%0d writes", i), 64'(wr), 64'(tbl[i].w));
      check($sformatf("vec%0d frame_done", i), 64'(dn), 64'(tbl[i].d));
      check($sformatf("vec%0d len_err", i), 64'(er), 64'(tbl[i].e));
      check($sformatf("vec%0d sink_3_4", i), 64'(s3), 64'(tbl[i].s));
      check($sformatf("vec%0d twdl", i), 64'(tw), 64'(tbl[i].t));
    end

    // randomized frames with gaps, restarts and stray eops
    for (int it = 0; it < 25; it++) begin
      clear_stim();
      n   = $urandom_range(0, 40);
      len = $urandom_range(1, 70);
      for (int c = 0; c < len; c++) begin
        st_v[c] = ($urandom_range(0, 9) != 0);
        st_s[c] = (c == 0) || ($urandom_range(0, 24) == 0);
        st_e[c] = ($urandom_range(0, 19) == 0);
      end
      run_stim(n, len, wr, dn, er, s3, tw);
    end

    // reset in the middle of a frame squashes pending writes
    frame_len = WC'(4);
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      in_valid = 1'b1; in_sop = (c == 0); in_eop = 1'b0;
      in_data = WD'(c + 100);
      rst_n = (c == 3) ? 1'b0 : 1'b1;
    end
    @(posedge clk);
    #1;
    check("midrst wr_en", 64'(wr_en7), 64'd0);
    check("midrst wr_addr", 64'(wr_addr7), 64'd0);
    check("midrst wr_data", 64'(wr_data7), 64'd0);
    check("midrst frame_done", 64'(done7), 64'd0);
    check("midrst len_err", 64'(err7), 64'd0);
    check("midrst sink_3_4", 64'(s34_7), 64'd0);
    dval = WD'(36'h9_1234_5678);
    @(negedge clk);
    rst_n = 1'b1; in_valid = 1'b1; in_sop = 1'b0; in_data = dval;
    @(negedge clk);
    in_valid = 1'b0; in_data = '0;
    @(posedge clk);
    #1;
    check("postrst wr_en", 64'(wr_en7), 64'h40);
    check("postrst wr_addr", 64'(wr_addr7), 64'd0);
    check("postrst wr_data", 64'(wr_data7), 64'(dval));
    repeat (2) @(negedge clk);

    // Sink-state timeout: level rises once the count has reached TIMEOUT
    fsm_sink = 1'b1;
    for (int e = 1; e <= 3000; e++) begin
      @(posedge clk);
      #1;
      check($sformatf("over_time edge=%0d", e), 64'(ovt7), 64'(e >= TMO + 1));
    end
    @(negedge clk);
    fsm_sink = 1'b0;
    @(posedge clk);
    #1;
    check("over_time clear", 64'(ovt7), 64'd0);
    @(negedge clk);
    fsm_sink = 1'b1;
    for (int e = 1; e <= 5; e++) begin
      @(posedge clk);
      #1;
      check($sformatf("over_time restart edge=%0d", e), 64'(ovt7), 64'd0);
    end
    @(negedge clk);
    fsm_sink = 1'b0;

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/mrd_sink_wrgen.md
Name: mrd_sink_wrgen

Overview:
Parametrised sink-side write generator for the mixed-radix DFT memory.
- Accepts a streaming frame of frame_len complex samples.
- Distributes the samples round-robin across NBANK single-port RAM banks: one-hot write enable, shared address, aligned write data.
- Generates the 3/4-frame and twiddle-start strobes, frame completion, frame-length error and Sink-state timeout for the top-level FSM.
- Successor to the fixed 7-bank sink: bank count, widths, timeout and twiddle lead are parameters. Adds SOP restart, EOP length checking, excess-sample dropping and a level (saturating) timeout.

Parameters:
NBANK, 7, number of RAM banks (2..16)
wADDR, 8, bank address width
wCNT, 12, sample counter and frame_len width
wDATA, 36, sample data width (I/Q concatenated)
TIMEOUT, 2047, Sink-state cycle count at which over_time asserts (< 2^wCNT)
TWDL_LEAD, 6, twdl_sop_sink fires this many samples before the 3/4 point

Ports:
clk  in  1  clock
rst_n  in  1  synchronous active-low reset
fsm_sink  in  1  high while top FSM is in Sink state
frame_len  in  wCNT  N, points in the current frame; stable while in_valid is high
in_valid  in  1  sample valid; deassertion ends the frame
in_sop  in  1  first sample of frame (qualified by in_valid)
in_eop  in  1  last sample of frame (qualified by in_valid)
in_data  in  wDATA  sample
wr_en  out  NBANK  one-hot bank write enable
wr_addr  out  wADDR  shared bank address
wr_data  out  wDATA  write data
frame_done  out  1  pulse with write of sample N-1
len_err  out  1  frame-length error pulse
sink_3_4  out  1  pulse at 3/4 of frame
twdl_sop_sink  out  1  twiddle generator start pulse
over_time  out  1  Sink-state timeout level

Behaviour:
- Reset: every output 0; sample index k, bank pointer, address pointer and timeout counter all 0.
- Sample indexing:
  - k counts accepted samples within a frame.
  - k returns to 0 when in_valid is low.
  - in_sop with in_valid forces the sample to k=0, even mid-stream (restart; the previous frame is abandoned with no frame_done).
- Bank mapping:
  - Sample k goes to bank b = k mod NBANK, address k div NBANK.
  - Realised as a bank pointer that wraps at NBANK-1 and increments the address on wrap. No divider.
  - Bank 0 is the MSB of wr_en: wr_en = 1 << (NBANK-1-b).
- Latency: wr_en, wr_addr and wr_data appear exactly 2 cycles after the accepted sample (pointer stage, then output register). Back-to-back samples produce back-to-back writes.
- wr_en is all-zero when there is no write. wr_addr and wr_data are don't-care then but hold their last values.
- Excess samples: a sample with k ≥ N is dropped (no wr_en). len_err pulses on the first dropped sample only, on the same cycle the write would have occurred.
- EOP check:
  - in_eop on sample k with k ≠ N-1 and k < N → len_err pulses at that sample's write slot.
  - The counter then behaves as if in_valid dropped.
- frame_done: pulses coincident with the wr_en of sample k = N-1. It does not depend on in_eop.
- sink_3_4:
  - Q = N[wCNT-1:2] + N[wCNT-1:1] - 1, computed at wCNT+1 bits (no overflow).
  - Pulses 1 cycle after the sample with k == Q, and only if k ≠ 0.
- twdl_sop_sink:
  - T = N[wCNT-1:2] + N[wCNT-1:1] - TWDL_LEAD, computed signed at wCNT+1 bits.
  - Pulses 1 cycle after the sample with k == T, only if T ≥ 0.
- frame_len = 0: every sample is excess; len_err fires once; no other strobes.
- over_time:
  - Counter increments each cycle fsm_sink is high and saturates at TIMEOUT.
  - Counter clears the cycle after fsm_sink goes low.
  - over_time is registered high once the counter equals TIMEOUT and stays high until fsm_sink drops.
- Reset asserted mid-frame clears everything next edge. Writes already in the pipeline are squashed; wr_en is 0 the cycle after reset.
- Simultaneous in_sop and in_eop: a one-sample frame. Valid only if N = 1, otherwise len_err.

Test Plan:
- NBANK=7, N=28, continuous valid with sop/eop → wr_en cycles 1000000..0000001 four times; wr_addr 0,0..0,1,..3; first write 2 cycles after first sample; frame_done with 28th write; sink_3_4 one cycle after k=20; twdl_sop_sink one cycle after k=15; len_err never.
- NBANK=5, N=12 → banks 0-4, 0-4, 0-1; addresses 0,0,0,0,0,1,1,1,1,1,2,2.
- N=12 with 14 valid samples and no eop → writes for k=0..11 only; len_err one pulse at k=12's slot; frame_done once.
- in_eop at k=8 with N=12 → len_err at that slot; no frame_done; next sop starts at bank 0, addr 0. A mid-stream in_sop at k=5 restarts at bank 0, addr 0.
- fsm_sink held 3000 cycles with TIMEOUT=2047 → over_time rises at the registered count 2047 and stays high; clears 1 cycle after fsm_sink falls.
- N=4, TWDL_LEAD=6 → no twdl_sop_sink; sink_3_4 after k=2. Reset at k=3 → wr_en 0 next cycle, all outputs 0.
